// File: rtl/mag_detect_if.sv
`default_nettype none
// ============================================================================
// Module      : mag_detect_if
// Description : Sample, threshold and block-average bus of mag_detect.
//               The peak signal exists only when MAG_DETECT_PEAK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface mag_detect_if #(
    parameter int DATA_IN_WIDTH = 16
);
    logic [DATA_IN_WIDTH-1:0] mag;
    logic                     mag_valid;
    logic [DATA_IN_WIDTH-1:0] thr_hi;
    logic [DATA_IN_WIDTH-1:0] thr_lo;
    logic [DATA_IN_WIDTH-1:0] avg;
    logic                     avg_valid;
    logic                     avg_ready;
    logic                     detect;
    logic                     overrun;
`ifdef MAG_DETECT_PEAK_EN
    logic [DATA_IN_WIDTH-1:0] peak;
`endif

    // Upstream sample source plus downstream consumer.
    modport master (
        output mag, mag_valid, thr_hi, thr_lo, avg_ready,
`ifdef MAG_DETECT_PEAK_EN
        input  peak,
`endif
        input  avg, avg_valid, detect, overrun
    );

    // The detector block itself.
    modport slave (
        input  mag, mag_valid, thr_hi, thr_lo, avg_ready,
`ifdef MAG_DETECT_PEAK_EN
        output peak,
`endif
        output avg, avg_valid, detect, overrun
    );
endinterface
`default_nettype wire

// File: rtl/mag_detect.sv
`default_nettype none
// ============================================================================
// Module      : mag_detect
// Description : Block averager of N = 2^LOG2_N magnitude samples with a
//               valid/ready result port, sticky overrun flag and a hysteresis
//               detector. Define MAG_DETECT_PEAK_EN to add per-block peak.
// Revision    : 1.0 - initial release
// ============================================================================
module mag_detect #(
    parameter int DATA_IN_WIDTH = 16,
    parameter int LOG2_N        = 4     // legal range 1..8
) (
    input wire          clk,
    input wire          rst,
    mag_detect_if.slave bus
);
    localparam int c_ACC_W = DATA_IN_WIDTH + LOG2_N;
    localparam logic [LOG2_N-1:0] c_CNT_LAST = '1;

    typedef enum logic [0:0] {
        ST_BELOW = 1'b0,
        ST_ABOVE = 1'b1
    } state_t;

    logic [c_ACC_W-1:0]       r_acc;
    logic [LOG2_N-1:0]        r_cnt;
    logic [DATA_IN_WIDTH-1:0] r_avg;
    logic                     r_avg_valid;
    logic                     r_overrun;
    state_t                   r_state;
    state_t                   w_state_next;

    logic                     w_last;
    logic [c_ACC_W-1:0]       w_sum;
    logic [DATA_IN_WIDTH-1:0] w_avg;

    // The Nth sample is folded in combinationally so the average registers
    // on the same edge that accepts it.
    assign w_last = bus.mag_valid && (r_cnt == c_CNT_LAST);
    assign w_sum  = r_acc + c_ACC_W'(bus.mag);
    assign w_avg  = w_sum[c_ACC_W-1:LOG2_N];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc       <= '0;
            r_cnt       <= '0;
            r_avg       <= '0;
            r_avg_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (bus.mag_valid) begin
                r_cnt <= r_cnt + LOG2_N'(1);
                r_acc <= w_last ? '0 : w_sum;
            end
            if (w_last) begin
                r_avg       <= w_avg;
                r_avg_valid <= 1'b1;
                // A handshake on the completion edge consumes the old result.
                if (r_avg_valid && !bus.avg_ready) begin
                    r_overrun <= 1'b1;
                end
            end else if (r_avg_valid && bus.avg_ready) begin
                r_avg_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_BELOW;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Each state looks only at its own threshold, so crossed thresholds
    // still give a well-defined toggle rather than an ambiguous decision.
    always_comb begin
        w_state_next = r_state;
        if (w_last) begin
            case (r_state)
                ST_BELOW: if (w_avg >= bus.thr_hi) w_state_next = ST_ABOVE;
                ST_ABOVE: if (w_avg <  bus.thr_lo) w_state_next = ST_BELOW;
            endcase
        end
    end

    assign bus.avg       = r_avg;
    assign bus.avg_valid = r_avg_valid;
    assign bus.overrun   = r_overrun;
    assign bus.detect    = (r_state == ST_ABOVE);

`ifdef MAG_DETECT_PEAK_EN
    logic [DATA_IN_WIDTH-1:0] r_blk_max;
    logic [DATA_IN_WIDTH-1:0] r_peak;
    logic [DATA_IN_WIDTH-1:0] w_max;

    assign w_max = (bus.mag > r_blk_max) ? bus.mag : r_blk_max;

    // Peak follows avg exactly: it loads on completion and is never held
    // back by the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_blk_max <= '0;
            r_peak    <= '0;
        end else if (bus.mag_valid) begin
            if (w_last) begin
                r_peak    <= w_max;
                r_blk_max <= '0;
            end else begin
                r_blk_max <= w_max;
            end
        end
    end

    assign bus.peak = r_peak;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mag_detect.sv
`default_nettype none
// ============================================================================
// Module      : tb_mag_detect
// Description : Self-checking bench for mag_detect (DATA_IN_WIDTH=16, N=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mag_detect;
    localparam int c_W      = 16;
    localparam int c_LOG2_N = 2;
    localparam int c_N      = 1 << c_LOG2_N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    mag_detect_if #(.DATA_IN_WIDTH(c_W)) bus ();

    mag_detect #(.DATA_IN_WIDTH(c_W), .LOG2_N(c_LOG2_N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0][15:0] s;
        bit               gap;
        logic [15:0]      thr_hi;
        logic [15:0]      thr_lo;
        logic [15:0]      exp_avg;
        logic [15:0]      exp_peak;
        bit               exp_det;
    } vec_t;

    vec_t vecs[13];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] v);
        bus.mag       = v;
        bus.mag_valid = 1'b1;
        step();
        bus.mag_valid = 1'b0;
    endtask

    task automatic send_block(input logic [3:0][15:0] s, input bit gap);
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            if (gap && i < 3) step();
        end
    endtask

    // Behavioural reference for the random phase.
    logic [15:0] q[$];
    int m_avg, m_valid, m_ovr, m_det, m_peak;

    task automatic model_reset();
        q.delete();
        m_avg = 0; m_valid = 0; m_ovr = 0; m_det = 0; m_peak = 0;
    endtask

    task automatic model_cycle();
        int sum, mx, nav;
        bit comp;
        comp = 1'b0;
        sum  = 0;
        mx   = 0;
        if (bus.mag_valid) q.push_back(bus.mag);
        if (q.size() == c_N) begin
            foreach (q[k]) begin
                sum += int'(q[k]);
                if (int'(q[k]) > mx) mx = int'(q[k]);
            end
            q.delete();
            comp = 1'b1;
        end
        if (comp) begin
            nav = sum / c_N;
            if (m_valid != 0 && !bus.avg_ready) m_ovr = 1;
            m_avg   = nav;
            m_valid = 1;
            m_peak  = mx;
            if (m_det == 0 && nav >= int'(bus.thr_hi)) m_det = 1;
            else if (m_det == 1 && nav < int'(bus.thr_lo)) m_det = 0;
        end else if (m_valid != 0 && bus.avg_ready) begin
            m_valid = 0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vecs[0]  = '{{4{16'd5}},               1'b0, 16'd100, 16'd50,  16'd5,     16'd5,     1'b0};
        vecs[1]  = '{{16'd4,16'd3,16'd2,16'd1}, 1'b1, 16'd100, 16'd50,  16'd2,     16'd4,     1'b0};
        vecs[2]  = '{{4{16'd120}},             1'b0, 16'd100, 16'd50,  16'd120,   16'd120,   1'b1};
        vecs[3]  = '{{4{16'd70}},              1'b0, 16'd100, 16'd50,  16'd70,    16'd70,    1'b1};
        vecs[4]  = '{{4{16'd40}},              1'b0, 16'd100, 16'd50,  16'd40,    16'd40,    1'b0};
        vecs[5]  = '{{4{16'd60}},              1'b0, 16'd100, 16'd50,  16'd60,    16'd60,    1'b0};
        vecs[6]  = '{{4{16'd65535}},           1'b0, 16'd100, 16'd50,  16'd65535, 16'd65535, 1'b1};
        vecs[7]  = '{{16'd3,16'd0,16'd0,16'd0}, 1'b0, 16'd100, 16'd50,  16'd0,     16'd3,     1'b0};
        vecs[8]  = '{{4{16'd20}},              1'b0, 16'd10,  16'd200, 16'd20,    16'd20,    1'b1};
        vecs[9]  = '{{4{16'd100}},             1'b0, 16'd10,  16'd200, 16'd100,   16'd100,   1'b0};
        vecs[10] = '{{4{16'd100}},             1'b0, 16'd100, 16'd50,  16'd100,   16'd100,   1'b1};
        vecs[11] = '{{4{16'd50}},              1'b0, 16'd100, 16'd50,  16'd50,    16'd50,    1'b1};
        vecs[12] = '{{16'd7,16'd6,16'd5,16'd4}, 1'b0, 16'd100, 16'd50,  16'd5,     16'd7,     1'b0};

        bus.mag = '0; bus.mag_valid = 1'b0; bus.avg_ready = 1'b1;
        bus.thr_hi = 16'd100; bus.thr_lo = 16'd50;
        rst = 1'b1;
        step(); step();
        rst = 1'b0;
        chk("reset_avg", bus.avg, 0);
        chk("reset_avg_valid", bus.avg_valid, 0);
        chk("reset_detect", bus.detect, 0);
        chk("reset_overrun", bus.overrun, 0);

        foreach (vecs[i]) begin
            bus.thr_hi = vecs[i].thr_hi;
            bus.thr_lo = vecs[i].thr_lo;
            send_block(vecs[i].s, vecs[i].gap);
            chk($sformatf("vec%0d_avg", i), bus.avg, vecs[i].exp_avg);
            chk($sformatf("vec%0d_valid", i), bus.avg_valid, 1);
            chk($sformatf("vec%0d_detect", i), bus.detect, vecs[i].exp_det);
            chk($sformatf("vec%0d_overrun", i), bus.overrun, 0);
`ifdef MAG_DETECT_PEAK_EN
            chk($sformatf("vec%0d_peak", i), bus.peak, vecs[i].exp_peak);
`endif
            step();
            chk($sformatf("vec%0d_valid_clear", i), bus.avg_valid, 0);
        end

        // Thresholds matter only on the completion edge.
        bus.thr_hi = 16'd0;
        send(16'd5); send(16'd5); send(16'd5);
        bus.thr_hi = 16'd1000;
        send(16'd5);
        bus.thr_hi = 16'd0;
        step(); step();
        chk("thr_sample_detect", bus.detect, 0);
        bus.thr_hi = 16'd100;

        // Backpressure: second completion overwrites and sets overrun.
        bus.avg_ready = 1'b0;
        send_block({4{16'd10}}, 1'b0);
        chk("bp_first_avg", bus.avg, 10);
        chk("bp_first_overrun", bus.overrun, 0);
        send_block({4{16'd20}}, 1'b0);
        chk("bp_second_avg", bus.avg, 20);
        chk("bp_second_valid", bus.avg_valid, 1);
        chk("bp_second_overrun", bus.overrun, 1);
        step();
        chk("bp_hold_valid", bus.avg_valid, 1);
        chk("bp_hold_avg", bus.avg, 20);
        bus.avg_ready = 1'b1;
        step();
        chk("bp_release_valid", bus.avg_valid, 0);
        chk("bp_sticky_overrun", bus.overrun, 1);

        // Mid-block reset, with detect high and overrun set beforehand.
        send_block({4{16'd200}}, 1'b0);
        chk("pre_reset_detect", bus.detect, 1);
        send(16'd9); send(16'd9);
        bus.mag = 16'd9; bus.mag_valid = 1'b1; rst = 1'b1;
        step();
        rst = 1'b0; bus.mag_valid = 1'b0;
        chk("mid_reset_overrun", bus.overrun, 0);
        chk("mid_reset_detect", bus.detect, 0);
        chk("mid_reset_avg", bus.avg, 0);
        send_block({4{16'd8}}, 1'b0);
        chk("post_reset_avg", bus.avg, 8);
        chk("post_reset_overrun", bus.overrun, 0);
        chk("post_reset_detect", bus.detect, 0);
        step();

        // Completion coinciding with a handshake does not flag overrun.
        bus.avg_ready = 1'b0;
        send_block({4{16'd30}}, 1'b0);
        send(16'd40); send(16'd40); send(16'd40);
        bus.avg_ready = 1'b1;
        send(16'd40);
        chk("hs_comp_avg", bus.avg, 40);
        chk("hs_comp_valid", bus.avg_valid, 1);
        chk("hs_comp_overrun", bus.overrun, 0);
        step();
        chk("hs_comp_clear", bus.avg_valid, 0);

        // Randomized phase against the behavioural model.
        rst = 1'b1;
        step();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 800; c++) begin
            bus.mag_valid = ($urandom % 4) != 0;
            bus.mag       = (($urandom % 8) == 0) ? 16'hFFFF : 16'($urandom_range(0, 255));
            bus.avg_ready = ($urandom % 3) != 0;
            if (($urandom % 6) == 0) begin
                bus.thr_hi = 16'($urandom_range(0, 255));
                bus.thr_lo = 16'($urandom_range(0, 255));
            end
            model_cycle();
            step();
            chk("rnd_avg", bus.avg, m_avg);
            chk("rnd_valid", bus.avg_valid, m_valid);
            chk("rnd_detect", bus.detect, m_det);
            chk("rnd_overrun", bus.overrun, m_ovr);
`ifdef MAG_DETECT_PEAK_EN
            chk("rnd_peak", bus.peak, m_peak);
`endif
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mag_detect.md
MAG_DETECT -- requirements
Module: mag_detect

Interface
REQ-001 Parameter DATA_IN_WIDTH, default 16, SHALL set the width of the unsigned magnitude input and the average output.
REQ-002 Parameter LOG2_N, default 4, SHALL set the block length N = 2^LOG2_N samples; legal range 1..8.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1  SHALL be a synchronous, active-high reset.
REQ-005 mag  input  DATA_IN_WIDTH  SHALL carry an unsigned magnitude sample from the upstream sqrt(x1^2+x2^2) stage.
REQ-006 mag_valid  input  1  SHALL qualify mag; mag is always accepted when mag_valid=1, with no upstream backpressure.
REQ-007 thr_hi  input  DATA_IN_WIDTH  SHALL be the unsigned detect-assert threshold.
REQ-008 thr_lo  input  DATA_IN_WIDTH  SHALL be the unsigned detect-release threshold.
REQ-009 avg  output  DATA_IN_WIDTH  SHALL be the registered block average.
REQ-010 avg_valid  output  1  SHALL indicate that avg holds an unconsumed result.
REQ-011 avg_ready  input  1  SHALL be the downstream accept; a transfer occurs when avg_valid=1 and avg_ready=1.
REQ-012 detect  output  1  SHALL be the registered hysteresis detector state.
REQ-013 overrun  output  1  SHALL be a sticky flag indicating that an unconsumed result was overwritten.
REQ-014 peak  output  DATA_IN_WIDTH  SHALL be present only when MAG_DETECT_PEAK_EN is defined (see Configuration).

Function
REQ-015 Accumulator width SHALL be DATA_IN_WIDTH+LOG2_N bits, so that N full-scale samples cannot overflow.
REQ-016 Sample counter SHALL run 0..N-1 and increment only on mag_valid=1, wrapping to 0 after the Nth sample.
REQ-017 On the Nth accepted sample, the block SHALL compute the average as (acc+mag)>>LOG2_N (truncating), clear acc to 0, and register the average into avg.
REQ-018 Latency: avg and avg_valid SHALL update in the cycle after the clock edge that accepts the Nth sample.
REQ-019 avg and avg_valid SHALL hold stable while avg_valid=1 and avg_ready=0, unless a new block completes (REQ-021).
REQ-020 Handshake without a new completion: avg_valid SHALL clear to 0.
REQ-021 New completion while avg_valid=1 and avg_ready=0: avg SHALL be overwritten, avg_valid SHALL stay 1, and overrun SHALL set to 1.
REQ-022 New completion in the same cycle as a handshake: avg SHALL load the new value, avg_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-023 overrun SHALL remain 1 until rst.
REQ-024 Detector FSM states BELOW (detect=0) and ABOVE (detect=1) SHALL be evaluated only against a newly completed average, in the same cycle avg loads.
REQ-025 BELOW -> ABOVE SHALL occur when the new average >= thr_hi; otherwise the FSM stays in BELOW.
REQ-026 ABOVE -> BELOW SHALL occur when the new average < thr_lo; otherwise the FSM stays in ABOVE.
REQ-027 Each state SHALL test only its own threshold, so behaviour remains deterministic even when thr_lo > thr_hi.
REQ-028 Thresholds SHALL be sampled at the completion edge only; changes at other times have no effect.

Reset
REQ-029 On rst=1, the block SHALL clear acc, the sample counter, avg, avg_valid, overrun and peak to 0, and set the FSM to BELOW (detect=0).
REQ-030 rst SHALL take priority over mag_valid and avg_ready in the same cycle.
REQ-031 Reset mid-block SHALL discard the partial sum; the next block starts at counter 0.

Configuration
REQ-032 With MAG_DETECT_PEAK_EN defined, the block SHALL track the maximum raw mag within each block and register it into peak together with avg, under the same overwrite rules as avg; a per-block max register is reset on each completion.
REQ-033 Without MAG_DETECT_PEAK_EN, the peak port and its logic SHALL be absent; all other behaviour is identical.

Verification (DATA_IN_WIDTH=16, LOG2_N=2, avg_ready=1 unless stated)
REQ-034 Constant input: mag=5 on four consecutive valid cycles -> one cycle later avg=5 and avg_valid=1, then avg_valid=0 the following cycle.
REQ-035 Truncation and gaps: samples 1,2,3,4 with an idle cycle between each -> avg=2; peak=4 when MAG_DETECT_PEAK_EN is defined.
REQ-036 Full scale: four samples of 65535 -> avg=65535, with no wrap.
REQ-037 Backpressure: avg_ready=0, two blocks of constant 10 then 20 -> avg=20, avg_valid=1, overrun=1; raise avg_ready -> avg_valid=0 next cycle, overrun remains 1.
REQ-038 Hysteresis: thr_hi=100, thr_lo=50, successive block averages 120, 70, 40, 60 -> detect = 1, 1, 0, 0.
REQ-039 Mid-block reset: samples 9,9, rst pulse, then 8,8,8,8 -> avg=8, overrun=0, detect=0.
